// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch front-end control.
// Synchronises and debounces the two active-low push-buttons, turns an
// accepted start/stop press into a one-cycle pulse, runs the IDLE/RUNNING/
// STOPPED state machine, and divides the board clock down to the centisecond
// count enable and the 1 Hz indicator LED.
module stopwatch_input_ctrl #(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 100,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       clr,
   input  logic       start_stop_n,
   input  logic       hold_n,
   output logic       count_en,
   output logic       run,
   output logic [1:0] state,
   output logic       ss_press,
   output logic       clk_ind
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int HALF = (TICK_HZ / 2 > 1) ? (TICK_HZ / 2) : 1;
   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [IW-1:0] IND_LAST   = IW'(HALF - 1);

   // Bit 0 is start/stop, bit 1 is hold; both are 1 when released.
   localparam int SS = 0;
   localparam int HD = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      STOPPED = 2'b10
   } state_t;

   logic [1:0]    btn_sync_p0;
   logic [1:0]    btn_sync_p1;
   logic [1:0]    stable;
   logic [DW-1:0] db_cnt [2];
   logic          ss_prev;
   state_t        cur;
   state_t        nxt;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_d;
   logic          tick;
   logic [IW-1:0] ind_cnt;

   // Two-flop synchroniser for both raw buttons.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         btn_sync_p0 <= 2'b11;
         btn_sync_p1 <= 2'b11;
      end else begin
         btn_sync_p0 <= {hold_n, start_stop_n};
         btn_sync_p1 <= btn_sync_p0;
      end
   end

   // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         stable <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (btn_sync_p1[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= btn_sync_p1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Press detect: one pulse on the falling edge of the debounced start/stop level.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         ss_prev  <= 1'b1;
         ss_press <= 1'b0;
      end else begin
         ss_prev  <= stable[SS];
         ss_press <= ss_prev & ~stable[SS];
      end
   end

   // State register; run is registered from the next state so it never glitches.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cur <= IDLE;
         run <= 1'b0;
      end else begin
         cur <= nxt;
         run <= (nxt == RUNNING);
      end
   end

   // Next state: clr wins over a coincident press, which is then dropped.
   always_comb begin
      nxt = cur;
      if (clr) begin
         nxt = IDLE;
      end else if (ss_press) begin
         case (cur)
            IDLE:    nxt = RUNNING;
            RUNNING: nxt = STOPPED;
            STOPPED: nxt = RUNNING;
            default: nxt = IDLE;
         endcase
      end
   end

   // Prescaler next value: parked at 0 in IDLE, free-running otherwise so a resume keeps its phase.
   always_comb begin
      presc_d = presc;
      if (clr || (cur == IDLE)) begin
         presc_d = '0;
      end else if (presc == PRESC_LAST) begin
         presc_d = '0;
      end else begin
         presc_d = presc + PW'(1);
      end
   end

   // Prescaler and a registered terminal-count flag so count_en is a pure AND of flops.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         presc <= presc_d;
         tick  <= (presc_d == PRESC_LAST);
      end
   end

   // Hold suppresses the centisecond enable but leaves the prescaler running.
   assign count_en = tick & run & stable[HD];
   assign state    = cur;

   // Indicator LED toggles every HALF counted centiseconds, giving a 1 s period.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         ind_cnt <= '0;
         clk_ind <= 1'b0;
      end else if (clr) begin
         ind_cnt <= '0;
         clk_ind <= 1'b0;
      end else if (count_en) begin
         if (ind_cnt == IND_LAST) begin
            ind_cnt <= '0;
            clk_ind <= ~clk_ind;
         end else begin
            ind_cnt <= ind_cnt + IW'(1);
         end
      end
   end

endmodule

// File: doc/stopwatch_input_ctrl.md
Name: stopwatch_input_ctrl

Overview:
- Front-end control stage that sits directly upstream of the Stopwatch counter/display datapath.
- Conditions the raw active-low start_stop and hold push-buttons: 2-flop synchronise, debounce, single-cycle press detect.
- Runs the run/stop state machine and divides the 50 MHz board clock down to a centisecond enable (count_en) for the BCD counter chain.
- Also produces the 1 Hz clock-indicator LED drive.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 100, tick rate; DIV = CLK_HZ/TICK_HZ; must divide exactly, DIV >= 2.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button change (10 ms).

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear from the stopwatch reset path; active-high.
- start_stop_n  in  1  raw button; 0 = pressed.
- hold_n  in  1  raw button; 0 = pressed.
- count_en  out  1  one-cycle pulse; advance counter by 1 cs.
- run  out  1  1 while in RUNNING.
- state  out  2  00 IDLE, 01 RUNNING, 10 STOPPED.
- ss_press  out  1  one-cycle debounced start_stop press pulse.
- clk_ind  out  1  square wave, 1 s period while counting.

Behaviour:
Reset:
- reset=1 asynchronously forces: sync flops=1, debounced states=1, debounce counters=0, state=IDLE, prescaler=0, tick counter=0.
- All outputs 0.

Synchroniser:
- Two flops per button; reset value 1.

Debouncer (per button):
- Counter increments while the synced value != the stable value.
- Counter clears to 0 on any cycle where they are equal.
- When the counter reaches DEBOUNCE_CYCLES-1 with inputs still differing: stable takes the synced value on the next edge, and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no change.
- Required latency: ss_press is high exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples start_stop_n=0.

Press detect:
- ss_press = registered (stable_prev & ~stable).
- Exactly 1 cycle per accepted press.
- Release edges produce nothing.
- A held button produces one pulse only.

FSM, evaluated on ss_press:
- IDLE→RUNNING.
- RUNNING→STOPPED.
- STOPPED→RUNNING.
- No other transitions, except clr.
- run is asserted from the cycle after ss_press.

clr:
- Forces IDLE, prescaler=0, tick counter=0, clk_ind=0.
- clr has priority over a simultaneous ss_press: the result is IDLE, and that press is discarded.

Prescaler:
- Counts 0..DIV-1 and wraps; tick when at DIV-1.
- Free-running in RUNNING and STOPPED.
- Held at 0 in IDLE.
- Consequence: the first tick after start from IDLE occurs DIV cycles after run rises.
- Resuming from STOPPED keeps the phase; fractional cs is not lost.

Count enable and hold:
- count_en = tick & run & hold_stable_pressed_n.
- While debounced hold is pressed, count_en is suppressed (elapsed time is lost); the prescaler keeps running.

clk_ind:
- Mod-(TICK_HZ/2) counter advanced by count_en; toggle clk_ind on wrap.
- Frozen while stopped, held, or in IDLE.

Width rules:
- Counters sized $clog2 of their terminal count.
- No output glitches: all outputs registered except count_en, which is a single AND of registered terms.

Simultaneous events:
- Start press and hold both pressed: transition happens; count_en stays suppressed until hold is released.
- reset mid-debounce discards the partial count.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_CYCLES=4.
1. Reset/idle: reset pulse, buttons released for 50 cycles → all outputs 0, state=00, no count_en.
2. Debounce + start: start_stop_n low for 20 cycles → exactly one ss_press at edge 7 after the press; run=1 next cycle; first count_en 10 cycles after run; then one count_en every 10 cycles. A 3-cycle low glitch → no ss_press.
3. Hold: while RUNNING, hold_n low 60 cycles → count_en suppressed from debounce-accept until 4+3 cycles after release; count of count_en pulses over 100 cycles equals 10 minus suppressed ticks (checked against model); state stays 01.
4. Stop/resume: second press → state=10, no count_en; third press → state=01; first count_en arrives at the preserved prescaler phase (≤10 cycles); clk_ind toggles after every 50 count_en pulses only.
5. clr priority: assert clr on the same cycle as ss_press from RUNNING → state=00, run=0, clk_ind=0, prescaler restarts at 0.
6. Async reset mid-operation: assert reset between clock edges while RUNNING mid-debounce → outputs 0 immediately (before the next edge); after release, a fresh press needs the full 4+3 cycle latency.
